// File: rtl/mul_seq_32bit.sv
// ---------------------------------------------------------------------------
// mul_seq_32bit
// Multi-cycle shift-and-add multiplier for the RV32M MUL, MULH, MULHSU and
// MULHU operations. Operands are reduced to magnitudes at load. One 32-bit
// add per cycle accumulates into a 65-bit product/multiplier shift register.
// A final cycle applies the sign, negating the 64-bit product when needed.
//
// Ports:
//   clk     - single clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - operation request, sampled only while idle
//   op      - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (captured at start)
//   a, b    - rs1 / rs2 operands (captured at start)
//   busy    - high from the edge after start until done is asserted
//   done    - one-cycle pulse, result valid
//   result  - registered; low word for MUL, high word otherwise
//
// Also contains full_adder_32bit, the shared 32-bit ripple adder.
// ---------------------------------------------------------------------------

// 32-bit adder with carry in/out, the only arithmetic datapath element.
module full_adder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        c_in,
   output logic [31:0] sum,
   output logic        c_out
);
   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
endmodule

module mul_seq_32bit #(
   parameter int ZERO_BYPASS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } state_t;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   state_t      state_r;
   state_t      state_s;
   logic [1:0]  op_r;
   logic [31:0] mcand_r;
   logic [64:0] p_r;
   logic [4:0]  cnt_r;
   logic        neg_r;
   logic        busy_r;
   logic        done_r;
   logic [31:0] result_r;

   logic        sign_a_s;
   logic        sign_b_s;
   logic [31:0] mag_a_s;
   logic [31:0] mag_b_s;
   logic        zero_bypass_s;
   logic [31:0] add_sum_s;
   logic        add_c_s;
   logic [32:0] shift_in_s;
   logic [64:0] p_next_s;
   logic [31:0] neg_lo_s;
   logic        neg_lo_c_s;
   logic [31:0] neg_hi_s;
   logic        neg_hi_c_s;
   logic [63:0] prod_s;
   logic        unused_s;

   // Operand signedness and magnitudes; only the signed operands contribute a sign.
   always_comb begin
      sign_a_s = a[31] & ((op == OP_MULH) | (op == OP_MULHSU));
      sign_b_s = b[31] & (op == OP_MULH);
      if (sign_a_s) begin
         mag_a_s = ~a + 32'd1;
      end else begin
         mag_a_s = a;
      end
      if (sign_b_s) begin
         mag_b_s = ~b + 32'd1;
      end else begin
         mag_b_s = b;
      end
      zero_bypass_s = (ZERO_BYPASS != 0) && ((a == 32'd0) || (b == 32'd0));
   end

   // Accumulate adder: high half of the product plus the multiplicand.
   full_adder_32bit u_add (
      .a     (p_r[63:32]),
      .b     (mcand_r),
      .c_in  (1'b0),
      .sum   (add_sum_s),
      .c_out (add_c_s)
   );

   // Two's-complement negate of the 64-bit product, low word first.
   full_adder_32bit u_neg_lo (
      .a     (~p_r[31:0]),
      .b     (32'd0),
      .c_in  (1'b1),
      .sum   (neg_lo_s),
      .c_out (neg_lo_c_s)
   );

   full_adder_32bit u_neg_hi (
      .a     (~p_r[63:32]),
      .b     (32'd0),
      .c_in  (neg_lo_c_s),
      .sum   (neg_hi_s),
      .c_out (neg_hi_c_s)
   );

   // The negate carry-out and the always-zero top product bit carry no information.
   assign unused_s = ^{neg_hi_c_s, p_r[64]};

   // One shift-and-add step: add only when the current multiplier bit is set.
   always_comb begin
      if (p_r[0]) begin
         shift_in_s = {add_c_s, add_sum_s};
      end else begin
         shift_in_s = {1'b0, p_r[63:32]};
      end
      p_next_s = {1'b0, shift_in_s, p_r[31:1]};
      if (neg_r) begin
         prod_s = {neg_hi_s, neg_lo_s};
      end else begin
         prod_s = p_r[63:0];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (zero_bypass_s) begin
                  state_s = SIGN;
               end else begin
                  state_s = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == 5'd31) begin
               state_s = SIGN;
            end else begin
               state_s = CALC;
            end
         end
         SIGN:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r     <= 2'b00;
         mcand_r  <= 32'd0;
         p_r      <= 65'd0;
         cnt_r    <= 5'd0;
         neg_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= 32'd0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_r    <= op;
                  mcand_r <= mag_a_s;
                  neg_r   <= sign_a_s ^ sign_b_s;
                  cnt_r   <= 5'd0;
                  busy_r  <= 1'b1;
                  if (zero_bypass_s) begin
                     p_r <= 65'd0;
                  end else begin
                     p_r <= {33'd0, mag_b_s};
                  end
               end
            end
            CALC: begin
               p_r   <= p_next_s;
               cnt_r <= cnt_r + 5'd1;
            end
            SIGN: begin
               if (op_r == OP_MUL) begin
                  result_r <= prod_s[31:0];
               end else begin
                  result_r <= prod_s[63:32];
               end
               done_r <= 1'b1;
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

endmodule

// File: tb/tb_mul_seq_32bit.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_32bit
// Self-checking bench for mul_seq_32bit. Expected results come from a 64-bit
// arithmetic model, are queued when an operation is started and compared when
// done pulses. Latency, busy/done behaviour, the ignored start while busy and
// an asynchronous reset in mid-operation are also checked.
// ---------------------------------------------------------------------------
module tb_mul_seq_32bit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   mul_seq_32bit #(.ZERO_BYPASS(1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xe;
      logic [63:0] ye;
      logic [63:0] p;
      xe = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'd0, x};
      ye = (o == 2'b01) ? {{32{y[31]}}, y} : {32'd0, y};
      p  = xe * ye;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Start one operation, wait (bounded) for done, check latency and result.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      int n;
      int lat;
      bit got;
      logic [31:0] e;
      lat = (x == 32'd0 || y == 32'd0) ? 1 : 33;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      exp_q.push_back(model(o, x, y));
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      n = 0; got = 1'b0;
      while (n < 100 && !got) begin
         @(posedge clk);
         n++;
         #1;
         if (done) got = 1'b1;
      end
      check("done_seen", {31'd0, got}, 32'd1);
      check("latency", n, lat);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("result", result, e);
      end else begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end
      @(posedge clk);
      #1 check("done_pulse_end", {31'd0, done}, 32'd0);
   endtask

   initial begin
      int ndone;
      logic [31:0] e;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      run_op(2'b00, 32'd7, 32'd6);
      run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(2'b01, 32'h80000000, 32'h80000000);
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(2'b10, 32'hFFFFFFFF, 32'd2);
      run_op(2'b00, 32'hFFFFFFFF, 32'd2);
      run_op(2'b01, 32'hFFFFFFF9, 32'd6);
      run_op(2'b00, 32'hFFFFFFF9, 32'd6);
      run_op(2'b10, 32'd6, 32'hFFFFFFF9);
      for (int i = 0; i < 6; i++) begin
         run_op(i[1:0], $urandom, $urandom);
      end

      // Zero bypass plus a start pulse while busy that must be ignored.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd0; b = 32'd5;
      exp_q.push_back(model(2'b00, 32'd0, 32'd5));
      @(posedge clk);
      #1 a = 32'd3; b = 32'd3;
      check("bypass_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1 start = 1'b0;
      check("bypass_done", {31'd0, done}, 32'd1);
      e = exp_q.pop_front();
      check("bypass_result", result, e);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 if (done) ndone++;
      end
      check("ignored_start_no_done", ndone, 0);
      check("ignored_start_result", result, e);

      // Nonzero result so the reset clear is visible.
      run_op(2'b00, 32'd9, 32'd9);

      // Asynchronous reset in the middle of MUL 7*6.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_result", result, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      run_op(2'b00, 32'd3, 32'd5);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
